// File: rtl/glyph_text_renderer.sv
// Text overlay: NCHAR-slot glyph buffer rendered as 5x5-cell bitmaps, with an
// optional blink. Pixel path is two registered stages; a small FSM blanks the buffer.
//
// state    | meaning
// ST_CLEAR | sweep writes blank ID 63 into every slot, writes blocked
// ST_IDLE  | buffer stable, host writes accepted
module glyph_text_renderer #(
    parameter  int NCHAR        = 16,
    parameter  int CELL         = 4,
    parameter  int GAP          = 4,
    parameter  int BLINK_FRAMES = 30,
    localparam int PITCH        = 5 * CELL + GAP,
    localparam int AW           = $clog2(NCHAR)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [9:0]    xstart,
    input  logic [8:0]    ystart,
    input  logic [9:0]    x,
    input  logic [8:0]    y,
    input  logic          pix_req,
    input  logic          frame_tick,
    input  logic          blink_en,
    input  logic          clr,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [5:0]    wr_id,
    output logic          value,
    output logic          value_valid
);
    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    localparam int             FW      = $clog2(BLINK_FRAMES + 1);
    localparam logic [10:0]    XSPAN   = 11'(NCHAR * PITCH);
    localparam logic [10:0]    YSPAN   = 11'(5 * CELL);
    localparam logic [10:0]    PITCH_W = 11'(PITCH);
    localparam logic [10:0]    CELL_W  = 11'(CELL);

    state_t        r_state;
    logic [AW-1:0] r_sweep;
    logic          r_wr_ready;
    logic [5:0]    r_buf [NCHAR];
    logic [FW-1:0] r_frame;
    logic          r_blank;
    logic          r_v1, r_hit1;
    logic [AW-1:0] r_slot1;
    logic [2:0]    r_col1, r_row1;
    logic          r_value, r_value_valid;

    function automatic logic [4:0] rev5(input logic [4:0] r);
        for (int i = 0; i < 5; i++) rev5[i] = r[4-i];
    endfunction

    // Rows are written as drawn (leftmost char = column 0); row 0 lands in bits 4:0.
    function automatic logic [24:0] glyph(input logic [4:0] r0, r1, r2, r3, r4);
        glyph = {rev5(r4), rev5(r3), rev5(r2), rev5(r1), rev5(r0)};
    endfunction

    function automatic logic [24:0] rom(input logic [5:0] id);
        case (id)
            6'd0:                      rom = glyph(5'b11110, 5'b10001, 5'b11110, 5'b10000, 5'b10000); // P
            6'd1, 6'd4, 6'd8, 6'd21:   rom = glyph(5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111); // L
            6'd2, 6'd14, 6'd17:        rom = glyph(5'b01110, 5'b10001, 5'b11111, 5'b10001, 5'b10001); // A
            6'd3:                      rom = glyph(5'b10001, 5'b01010, 5'b00100, 5'b00100, 5'b00100); // Y
            6'd5, 6'd7, 6'd22:         rom = glyph(5'b11111, 5'b10000, 5'b11110, 5'b10000, 5'b11111); // E
            6'd6:                      rom = glyph(5'b10001, 5'b10001, 5'b10001, 5'b01010, 5'b00100); // V
            6'd9:                      rom = glyph(5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b01110); // 1
            6'd10:                     rom = glyph(5'b11110, 5'b00001, 5'b01110, 5'b10000, 5'b11111); // 2
            6'd11:                     rom = glyph(5'b11110, 5'b00001, 5'b01110, 5'b00001, 5'b11110); // 3
            6'd12:                     rom = glyph(5'b10001, 5'b10001, 5'b10101, 5'b10101, 5'b01010); // W
            6'd13:                     rom = glyph(5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001); // H
            6'd15:                     rom = glyph(5'b01111, 5'b10000, 5'b10000, 5'b10000, 5'b01111); // C
            6'd16:                     rom = glyph(5'b10001, 5'b10010, 5'b11100, 5'b10010, 5'b10001); // K
            6'd18:                     rom = glyph(5'b00000, 5'b00000, 5'b01110, 5'b00000, 5'b00000); // -
            6'd19:                     rom = glyph(5'b10001, 5'b11011, 5'b10101, 5'b10001, 5'b10001); // M
            6'd20:                     rom = glyph(5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b01110); // O
            default:                   rom = 25'd0;
        endcase
    endfunction

    logic [10:0] w_rx, w_ry, w_q, w_rem, w_col, w_row;
    logic        w_hit;
    assign w_rx  = {1'b0, x} - {1'b0, xstart};
    assign w_ry  = {2'b00, y} - {2'b00, ystart};
    assign w_q   = w_rx / PITCH_W;
    assign w_rem = w_rx - w_q * PITCH_W;
    assign w_col = w_rem / CELL_W;
    assign w_row = w_ry / CELL_W;
    assign w_hit = !w_rx[10] && !w_ry[10] && (w_rx < XSPAN) && (w_ry < YSPAN) && (w_col < 11'd5);

    logic w_unused_bits;
    assign w_unused_bits = ^{w_q, w_col[10:3], w_row[10:3]};

    logic          w_addr_ok;
    if (NCHAR == (1 << AW)) begin : g_pow2
        assign w_addr_ok = 1'b1;
    end else begin : g_npow2
        assign w_addr_ok = ({1'b0, wr_addr} < (AW + 1)'(NCHAR));
    end

    logic          w_wr_fire;
    logic [24:0]   w_bitmap;
    logic [4:0]    w_idx;
    logic          w_lit;
    assign w_wr_fire = r_wr_ready & wr_valid & ~clr & w_addr_ok;
    // Combinational read of the register array: sees contents before this edge's write.
    assign w_bitmap  = rom(r_buf[r_slot1]);
    assign w_idx     = {2'b00, r_row1} * 5'd5 + {2'b00, r_col1};
    assign w_lit     = r_hit1 & w_bitmap[w_idx] & ~r_blank & (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_CLEAR;
            r_sweep    <= '0;
            r_wr_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (clr) begin
                        r_sweep <= '0;
                    end else if (r_sweep == AW'(NCHAR - 1)) begin
                        r_state    <= ST_IDLE;
                        r_wr_ready <= 1'b1;
                        r_sweep    <= '0;
                    end else begin
                        r_sweep <= r_sweep + AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        r_state    <= ST_CLEAR;
                        r_wr_ready <= 1'b0;
                        r_sweep    <= '0;
                    end
                end
                default: begin
                    r_state    <= ST_CLEAR;
                    r_wr_ready <= 1'b0;
                    r_sweep    <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR)
            r_buf[r_sweep] <= 6'd63;
        else if (w_wr_fire)
            r_buf[wr_addr] <= wr_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= '0;
            r_blank <= 1'b0;
        end else if (!blink_en) begin
            r_frame <= '0;
            r_blank <= 1'b0;
        end else if (frame_tick) begin
            if (r_frame == FW'(BLINK_FRAMES - 1)) begin
                r_frame <= '0;
                r_blank <= ~r_blank;
            end else begin
                r_frame <= r_frame + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1          <= 1'b0;
            r_hit1        <= 1'b0;
            r_slot1       <= '0;
            r_col1        <= '0;
            r_row1        <= '0;
            r_value       <= 1'b0;
            r_value_valid <= 1'b0;
        end else begin
            r_v1          <= pix_req;
            r_hit1        <= w_hit;
            r_slot1       <= w_q[AW-1:0];
            r_col1        <= w_col[2:0];
            r_row1        <= w_row[2:0];
            r_value       <= r_v1 & w_lit;
            r_value_valid <= r_v1;
        end
    end

    assign wr_ready    = r_wr_ready;
    assign value       = r_value;
    assign value_valid = r_value_valid;
endmodule

// File: tb/tb_glyph_text_renderer.sv
// Directed bench for glyph_text_renderer: vector table for pixel hits/misses plus
// hand-written sequences for sweep, same-cycle write, blink and mid-sweep reset.
module tb_glyph_text_renderer;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [9:0]    xstart, x;
    logic [8:0]    ystart, y;
    logic          pix_req, frame_tick, blink_en, clr, wr_valid;
    logic          wr_ready, value, value_valid;
    logic [AW-1:0] wr_addr;
    logic [5:0]    wr_id;

    int n_checks = 0;
    int n_fail   = 0;

    glyph_text_renderer #(.BLINK_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .xstart(xstart), .ystart(ystart), .x(x), .y(y),
        .pix_req(pix_req), .frame_tick(frame_tick), .blink_en(blink_en), .clr(clr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_id(wr_id),
        .value(value), .value_valid(value_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge two clocks later with the result.
    task automatic pix(input logic [9:0] px, input logic [8:0] py,
                       output logic v, output logic vv, output logic vv_mid);
        x = px; y = py; pix_req = 1'b1;
        @(negedge clk);
        pix_req = 1'b0;
        vv_mid = value_valid;
        @(negedge clk);
        v = value; vv = value_valid;
    endtask

    task automatic wr(input int a, input int id);
        wr_valid = 1'b1; wr_addr = AW'(a); wr_id = 6'(id);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!wr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic       exp;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [9:0] dash_x(input int s);
        return 10'(100 + 24 * s + 13);
    endfunction

    initial begin
        logic v, vv, vm, seen;
        int n;
        logic blink_exp[5];

        vecs[0]  = '{10'd161, 9'd59, 1'b1};
        vecs[1]  = '{10'd161, 9'd55, 1'b0};
        vecs[2]  = '{10'd120, 9'd59, 1'b0};
        vecs[3]  = '{10'd99,  9'd59, 1'b0};
        vecs[4]  = '{10'd484, 9'd59, 1'b0};
        vecs[5]  = '{10'd152, 9'd59, 1'b1};
        vecs[6]  = '{10'd148, 9'd59, 1'b0};
        vecs[7]  = '{10'd164, 9'd59, 1'b0};
        vecs[8]  = '{10'd161, 9'd58, 1'b1};
        vecs[9]  = '{10'd161, 9'd62, 1'b0};
        vecs[10] = '{10'd161, 9'd49, 1'b0};
        vecs[11] = '{10'd161, 9'd70, 1'b0};
        vecs[12] = '{10'd113, 9'd59, 1'b0};
        vecs[13] = '{10'd185, 9'd61, 1'b1};
        vecs[14] = '{10'd171, 9'd59, 1'b0};
        vecs[15] = '{10'd172, 9'd59, 1'b0};
        blink_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        xstart = 10'd100; ystart = 9'd50; x = '0; y = '0;
        pix_req = 0; frame_tick = 0; blink_en = 0; clr = 0; wr_valid = 0;
        wr_addr = '0; wr_id = '0;

        repeat (3) @(negedge clk);
        check("rst_value", value, 0);
        check("rst_value_valid", value_valid, 0);
        check("rst_wr_ready", wr_ready, 0);
        rst_n = 1'b1;
        wait_ready(n);
        check("sweep_cycles_after_reset", n, 16);
        check("vv_before_pix", value_valid, 0);

        wr(2, 18);
        wr(3, 18);
        for (int i = 0; i < 16; i++) begin
            pix(vecs[i].x, vecs[i].y, v, vv, vm);
            check($sformatf("vec%0d_value", i), v, vecs[i].exp);
            check($sformatf("vec%0d_valid", i), vv, 1);
            if (i == 0) check("vec0_valid_after_1cycle", vm, 0);
        end

        // Write to slot 3 lands in the same cycle stage 2 reads slot 3: old ID must be used.
        x = dash_x(3); y = 9'd59; pix_req = 1'b1;
        @(negedge clk);
        pix_req = 1'b0; wr_valid = 1'b1; wr_addr = 4'd3; wr_id = 6'd63;
        @(negedge clk);
        wr_valid = 1'b0;
        check("same_cycle_write_old", value, 1);
        pix(dash_x(3), 9'd59, v, vv, vm);
        check("same_cycle_write_after", v, 0);

        blink_en = 1'b1;
        for (int t = 0; t < 5; t++) begin
            if (t > 0) begin
                frame_tick = 1'b1;
                @(negedge clk);
                frame_tick = 1'b0;
            end
            pix(10'd161, 9'd59, v, vv, vm);
            check($sformatf("blink_ticks%0d", t), v, blink_exp[t]);
        end
        blink_en = 1'b0;

        wr(15, 18);
        pix(dash_x(15), 9'd59, v, vv, vm);
        check("slot15_lit", v, 1);
        pulse_clr();
        pix(dash_x(15), 9'd59, v, vv, vm);
        check("value_zero_in_clear", v, 0);
        check("valid_in_clear", vv, 1);
        wait_ready(n);
        check("sweep_rest_after_clr", n, 14);
        pix(dash_x(15), 9'd59, v, vv, vm);
        check("slot15_blank_after_clr", v, 0);

        for (int s = 0; s < 16; s++) wr(s, 18);
        pix(dash_x(9), 9'd59, v, vv, vm);
        check("slot9_preload_lit", v, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; wr_valid = 1'b1; wr_addr = 4'd7; wr_id = 6'd18;
        seen = 1'b0;
        for (int c = 0; c < 16; c++) begin
            seen = seen | wr_ready;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        check("ready_low_during_sweep", seen, 0);
        check("ready_high_after_sweep", wr_ready, 1);
        for (int s = 0; s < 16; s++) begin
            pix(dash_x(s), 9'd59, v, vv, vm);
            check($sformatf("slot%0d_blank", s), v, 0);
        end

        pulse_clr();
        x = 10'd161; y = 9'd59; pix_req = 1'b1;
        repeat (7) @(negedge clk);
        check("vv_before_midsweep_reset", value_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_value_valid", value_valid, 0);
        check("midreset_value", value, 0);
        check("midreset_wr_ready", wr_ready, 0);
        pix_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        check("sweep_cycles_after_midreset", n, 16);
        wr(2, 18);
        pix(10'd161, 9'd59, v, vv, vm);
        check("lit_after_midreset", v, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
